kbd_matrix_scan: RTL and testbench

- 4x4 matrix keypad scanner with debounce. It is the input stage upstream of the gw8255 PPI and gw8259 PIC.
- Drives keypad columns active-low, samples rows, and debounces one key per press.
- Presents a status/code byte for PPI port A input (PAIN) and a level interrupt for PIC IR1.
- Software acknowledges a key by toggling a PPI port C output bit into `ack`.

---
 rtl/kbd_pkg.sv | 38 +++
 rtl/kbd_frame_scan.sv | 100 ++++++++++
 rtl/kbd_matrix_scan.sv | 151 +++++++++++++++
 tb/tb_kbd_matrix_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the 4x4 keypad scanner.
//   kbd_state_t  - debounce FSM states
//   frame_res_t  - classification of one complete 4-column scan
//   PEND/OVR/DOWN - bit positions inside the kbd_port status byte
//   SCAN_DIV_DEF / DEBOUNCE_FRAMES_DEF - default timing parameters
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kbd_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_res_t;

    localparam int PEND = 7;
    localparam int OVR  = 6;
    localparam int DOWN = 5;

    localparam int SCAN_DIV_DEF        = 50000;
    localparam int DEBOUNCE_FRAMES_DEF = 4;

    // Number of active-low (pressed) rows in a 4-bit row sample.
    function automatic logic [2:0] low_count(input logic [3:0] rows_n);
        logic [2:0] n;
        n = 3'd0;
        for (int r = 0; r < 4; r++) begin
            n = n + {2'b00, ~rows_n[r]};
        end
        return n;
    endfunction

endpackage

// File: rtl/kbd_frame_scan.sv
// kbd_frame_scan: column scanner and per-frame hit classifier.
//   clk, rst_n  - system clock, synchronous active-low reset
//   row_n[3:0]  - raw keypad rows (async, active-low)
//   col_n[3:0]  - registered column drive, one-hot-low
//   frame_done  - strobe on the last cycle of column 3's slot
//   result      - NONE/SINGLE/MULTI for the frame ending this cycle
//   code[3:0]   - row*4+col of the first hit (valid with SINGLE)
module kbd_frame_scan
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       frame_done,
    output frame_res_t result,
    output logic [3:0] code
);

    localparam int             SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic [3:0]    col_n_q;
    logic [1:0]    hit_cnt;
    logic [3:0]    hit_code;

    logic          slot_end;
    logic [2:0]    n_low;
    logic [2:0]    hit_sum;
    logic [1:0]    hit_next;
    logic [3:0]    code_next;
    logic [1:0]    first_row;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign frame_done = slot_end && (col_idx == 2'd3);
    assign col_nxt    = col_idx + 2'd1;
    assign col_n      = col_n_q;
    assign n_low      = low_count(row_sync);
    assign hit_sum    = {1'b0, hit_cnt} + n_low;

    always_comb begin
        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) first_row = 2'(r);
        end
    end

    // Hit count saturates at 2: anything beyond one intersection is MULTI.
    always_comb begin
        hit_next  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        code_next = hit_code;
        if (hit_cnt == 2'd0 && n_low != 3'd0) code_next = {first_row, col_idx};
    end

    always_comb begin
        code = code_next;
        case (hit_next)
            2'd0:    result = NONE;
            2'd1:    result = SINGLE;
            default: result = MULTI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col_n_q  <= 4'b1110;
            hit_cnt  <= 2'd0;
            hit_code <= 4'd0;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
            if (slot_end) begin
                slot_cnt <= '0;
                col_idx  <= col_nxt;
                col_n_q  <= ~(4'b0001 << col_nxt);
                if (frame_done) begin
                    hit_cnt  <= 2'd0;
                    hit_code <= 4'd0;
                end else begin
                    hit_cnt  <= hit_next;
                    hit_code <= code_next;
                end
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/kbd_matrix_scan.sv
// kbd_matrix_scan: 4x4 keypad scanner with debounce, PPI status byte and PIC IRQ.
//   clk, rst_n  - system clock, synchronous active-low reset
//   row_n[3:0]  - keypad rows (async, active-low)
//   col_n[3:0]  - keypad column drive, one-hot-low
//   ack         - rising edge clears pending/overrun
//   kbd_port    - {pending, overrun, key_down, 0, code[3:0]}
//   kbd_irq     - level interrupt, equals pending
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no key held, waiting for a single-key frame
// DEBOUNCE | counting identical single-key frames for cand
// PRESSED  | key accepted and reported, waiting for release
// RELEASE  | counting empty frames before returning to IDLE
module kbd_matrix_scan
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    input  logic       ack,
    output logic [7:0] kbd_port,
    output logic       kbd_irq
);

    localparam int            CW     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] FRAMES = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic       frame_done;
    frame_res_t result;
    logic [3:0] frame_code;

    kbd_state_t    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    code_q;
    logic          pend_q, ovr_q, ack_q;
    logic          accept;
    logic [3:0]    accept_code;
    logic          ack_edge;

    kbd_frame_scan #(.SCAN_DIV(SCAN_DIV)) u_frame_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .frame_done (frame_done),
        .result     (result),
        .code       (frame_code)
    );

    assign ack_edge = ack & ~ack_q;
    assign cnt_inc  = (cnt_q == FRAMES) ? cnt_q : cnt_q + ONE;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        accept_code = cand_q;
        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (result == SINGLE) begin
                        cand_d      = frame_code;
                        accept_code = frame_code;
                        cnt_d       = ONE;
                        if (FRAMES == ONE) begin
                            accept  = 1'b1;
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (result == SINGLE && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == FRAMES) begin
                            accept  = 1'b1;
                            state_d = PRESSED;
                        end
                    end else if (result == SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (result == NONE) begin
                        cnt_d   = ONE;
                        state_d = (FRAMES == ONE) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (result == NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == FRAMES) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Accept takes priority over an ack edge in the same cycle, so a
    // freshly reported key is never lost to a stale acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
            code_q  <= 4'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack;
            if (accept) begin
                code_q <= accept_code;
                pend_q <= 1'b1;
                ovr_q  <= ovr_q | pend_q;
            end else if (ack_edge) begin
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        kbd_port       = 8'h00;
        kbd_port[PEND] = pend_q;
        kbd_port[OVR]  = ovr_q;
        kbd_port[DOWN] = (state_q == PRESSED) || (state_q == RELEASE);
        kbd_port[3:0]  = code_q;
    end

    assign kbd_irq = pend_q;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// tb_kbd_matrix_scan: directed bench for kbd_matrix_scan with SCAN_DIV=4,
// DEBOUNCE_FRAMES=2 (16-cycle frames). A keypad model turns the held-key
// map into row_n from col_n; expected status bytes go through a queue.
module tb_kbd_matrix_scan;

    localparam int SD = 4;
    localparam int DF = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       ack;
    logic [7:0] kbd_port;
    logic       kbd_irq;

    logic [15:0] keys;
    logic [7:0]  exp_q[$];
    int          checks;
    int          errors;

    kbd_matrix_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .ack      (ack),
        .kbd_port (kbd_port),
        .kbd_irq  (kbd_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key index r*4+c shorts row r to column c.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, kbd_port=%h", tag, kbd_port);
        end else begin
            e = exp_q.pop_front();
            assert (kbd_port === e) else begin
                errors++;
                $error("FAIL %s: kbd_port=%h expected %h", tag, kbd_port, e);
            end
            checks++;
            assert (kbd_irq === e[7]) else begin
                errors++;
                $error("FAIL %s_irq: kbd_irq=%b expected %b", tag, kbd_irq, e[7]);
            end
        end
    endtask

    task automatic check_col(input logic [3:0] e, input string tag);
        checks++;
        assert (col_n === e) else begin
            errors++;
            $error("FAIL %s: col_n=%b expected %b", tag, col_n, e);
        end
    endtask

    // Advance to the first cycle after a frame end (col_n wraps 0111 -> 1110).
    task automatic to_frame_end();
        logic [3:0] prev;
        bit         seen;
        int         n;
        prev = col_n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            step(1);
            n++;
            if (prev == 4'b0111 && col_n == 4'b1110) seen = 1'b1;
            prev = col_n;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL frame_sync: no frame end within %0d cycles, col_n=%b expected wrap", n, col_n);
        end
    endtask

    // Advance into the last cycle of column 3's slot (the frame-end cycle).
    task automatic to_last_cycle();
        int n;
        n = 0;
        while (col_n != 4'b0111 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        assert (col_n === 4'b0111) else begin
            errors++;
            $error("FAIL col3_sync: col_n=%b expected 0111", col_n);
        end
        step(SD - 1);
    endtask

    initial begin
        logic [3:0] ec;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ack    = 1'b0;
        keys   = 16'h0200;                    // row2/col1, code 9
        step(2);
        check_col(4'b1110, "reset_col");
        exp_q.push_back(8'h00); check_port("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ec = ~(4'b0001 << (i / SD));
            check_col(ec, "scan_seq");
            step(1);
        end
        exp_q.push_back(8'h00); check_port("press9_f1");
        exp_q.push_back(8'hA9); to_frame_end(); check_port("press9_f2");

        keys = 16'h0000;
        exp_q.push_back(8'hA9); to_frame_end(); check_port("release9_f1");
        exp_q.push_back(8'h89); to_frame_end(); check_port("release9_f2");

        ack = 1'b1;
        exp_q.push_back(8'h09); step(1); check_port("ack_clear");
        exp_q.push_back(8'h09); step(3); check_port("ack_held");
        ack = 1'b0;
        step(1);

        to_frame_end();
        keys = 16'h0001;                      // row0/col0, code 0
        exp_q.push_back(8'h09); to_frame_end(); check_port("bounce_f1");
        keys = 16'h0000;
        exp_q.push_back(8'h09); to_frame_end(); check_port("bounce_f2");
        keys = 16'h0001;
        exp_q.push_back(8'h09); to_frame_end(); check_port("bounce_f3");
        exp_q.push_back(8'hA0); to_frame_end(); check_port("bounce_f4");
        keys = 16'h0000;
        exp_q.push_back(8'hA0); to_frame_end(); check_port("bounce_rel1");
        exp_q.push_back(8'h80); to_frame_end(); check_port("bounce_rel2");
        ack = 1'b1;
        exp_q.push_back(8'h00); step(1); check_port("ack_clear2");
        ack = 1'b0;
        step(1);

        to_frame_end();
        keys = 16'h8010;                      // row1/col0 + row3/col3
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(8'h00); to_frame_end(); check_port("multi");
        end
        keys = 16'h0000;
        to_frame_end();

        keys = 16'h0020;                      // row1/col1, code 5
        exp_q.push_back(8'h00); to_frame_end(); check_port("press5_f1");
        exp_q.push_back(8'hA5); to_frame_end(); check_port("press5_f2");
        keys = 16'h0000;
        exp_q.push_back(8'hA5); to_frame_end(); check_port("release5_f1");
        exp_q.push_back(8'h85); to_frame_end(); check_port("release5_f2");
        keys = 16'h1000;                      // row3/col0, code 12
        exp_q.push_back(8'h85); to_frame_end(); check_port("press12_f1");
        exp_q.push_back(8'hEC); to_frame_end(); check_port("overrun12");
        keys = 16'h0000;
        exp_q.push_back(8'hEC); to_frame_end(); check_port("release12_f1");
        exp_q.push_back(8'hCC); to_frame_end(); check_port("release12_f2");

        keys = 16'h0040;                      // row1/col2, code 6
        exp_q.push_back(8'hCC); to_frame_end(); check_port("press6_f1");
        to_last_cycle();
        ack = 1'b1;
        exp_q.push_back(8'hE6); step(1); check_port("ack_vs_accept");
        exp_q.push_back(8'hE6); step(2); check_port("ack_held2");
        ack = 1'b0;
        step(1);

        rst_n = 1'b0;
        step(1);
        check_col(4'b1110, "reset_mid_col");
        exp_q.push_back(8'h00); check_port("reset_mid");
        rst_n = 1'b1;
        exp_q.push_back(8'h00); to_frame_end(); check_port("rearm_f1");
        exp_q.push_back(8'hA6); to_frame_end(); check_port("rearm_f2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
